// File: rtl/wb_queue.sv
// Write-back queue: buffers execute-stage results until the register-file write port is free.
// Define WB_QUEUE_FORWARD_EN to build the operand forwarding lookup; otherwise fwd_hit_*/fwd_data_* read 0.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_data,
  input  logic                       wb_stall,
  output logic                       wb_enable,
  output logic [5:0]                 wb_addr,
  output logic [31:0]                wb_data,
  input  logic [4:0]                 fwd_addr_1,
  input  logic [4:0]                 fwd_addr_2,
  output logic                       fwd_hit_1,
  output logic                       fwd_hit_2,
  output logic [31:0]                fwd_data_1,
  output logic [31:0]                fwd_data_2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]    r_rd_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_not_empty;
  logic w_pop;
  logic w_accept;
  logic w_push;

  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty && !wb_stall;
  assign in_ready    = (r_count < DEPTH_C) || w_pop;
  assign w_accept    = in_valid && in_ready;
  // Writes to x0 are architecturally void, so they are accepted but never queued.
  assign w_push      = w_accept && (in_rd != 5'd0);

  assign wb_enable = w_pop;
  assign wb_addr   = w_not_empty ? {1'b0, r_rd_mem[r_head]} : 6'd0;
  assign wb_data   = w_not_empty ? r_data_mem[r_head] : 32'd0;
  assign count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is qualified by r_count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_tail]   <= in_rd;
      r_data_mem[r_tail] <= in_data;
    end
  end

`ifdef WB_QUEUE_FORWARD_EN
  logic        w_hit_1;
  logic        w_hit_2;
  logic [31:0] w_fwd_data_1;
  logic [31:0] w_fwd_data_2;

  // Walk oldest to newest so the youngest matching entry wins; the head being
  // popped is still visible, the request being accepted is not.
  always_comb begin
    logic [PW-1:0] w_idx;
    w_hit_1      = 1'b0;
    w_hit_2      = 1'b0;
    w_fwd_data_1 = 32'd0;
    w_fwd_data_2 = 32'd0;
    w_idx        = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if ((fwd_addr_1 != 5'd0) && (r_rd_mem[w_idx] == fwd_addr_1)) begin
          w_hit_1      = 1'b1;
          w_fwd_data_1 = r_data_mem[w_idx];
        end
        if ((fwd_addr_2 != 5'd0) && (r_rd_mem[w_idx] == fwd_addr_2)) begin
          w_hit_2      = 1'b1;
          w_fwd_data_2 = r_data_mem[w_idx];
        end
      end
    end
  end

  assign fwd_hit_1  = w_hit_1;
  assign fwd_hit_2  = w_hit_2;
  assign fwd_data_1 = w_fwd_data_1;
  assign fwd_data_2 = w_fwd_data_2;
`else
  logic w_fwd_unused;
  assign w_fwd_unused = ^{fwd_addr_1, fwd_addr_2};

  assign fwd_hit_1  = 1'b0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_1 = 32'd0;
  assign fwd_data_2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Testbench for wb_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        wb_enable;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  fwd_addr_1;
  logic [4:0]  fwd_addr_2;
  logic        fwd_hit_1;
  logic        fwd_hit_2;
  logic [31:0] fwd_data_1;
  logic [31:0] fwd_data_2;
  logic [2:0]  count;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall),
    .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of pending writes, oldest at index 0.
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];

  logic        e_pop, e_ready, e_hit1, e_hit2;
  logic [5:0]  e_addr;
  logic [31:0] e_data, e_fd1, e_fd2;
  logic [2:0]  e_count;

  task automatic compute_exp();
    e_count = 3'(q_rd.size());
    e_pop   = (q_rd.size() != 0) && !wb_stall;
    e_ready = (q_rd.size() < DEPTH) || e_pop;
    e_addr  = (q_rd.size() != 0) ? {1'b0, q_rd[0]} : 6'd0;
    e_data  = (q_rd.size() != 0) ? q_data[0] : 32'd0;
    e_hit1 = 1'b0; e_hit2 = 1'b0; e_fd1 = 32'd0; e_fd2 = 32'd0;
`ifdef WB_QUEUE_FORWARD_EN
    for (int i = q_rd.size() - 1; i >= 0; i--) begin
      if (!e_hit1 && fwd_addr_1 != 5'd0 && q_rd[i] == fwd_addr_1) begin
        e_hit1 = 1'b1; e_fd1 = q_data[i];
      end
      if (!e_hit2 && fwd_addr_2 != 5'd0 && q_rd[i] == fwd_addr_2) begin
        e_hit2 = 1'b1; e_fd2 = q_data[i];
      end
    end
`endif
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    compute_exp();
    @(posedge clk);
    if (e_pop) begin
      void'(q_rd.pop_front());
      void'(q_data.pop_front());
    end
    if (in_valid && e_ready && in_rd != 5'd0) begin
      q_rd.push_back(in_rd);
      q_data.push_back(in_data);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic st);
    in_valid = v; in_rd = rd; in_data = d; wb_stall = st;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 0; k < 2 * DEPTH && q_rd.size() != 0; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 5'd9, 32'h1111_2222, 1'b0);
    fwd_addr_1 = 5'd9; fwd_addr_2 = 5'd9;
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (wb_enable !== 1'b0 || wb_addr !== 6'd0 || wb_data !== 32'd0) begin
      fails++; $display("FAIL reset_wb got en=%b addr=%0d data=%h exp 0/0/0", wb_enable, wb_addr, wb_data);
    end
    tests++; if (fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b0 || fwd_data_1 !== 32'd0 || fwd_data_2 !== 32'd0) begin
      fails++; $display("FAIL reset_fwd got h1=%b h2=%b d1=%h d2=%h exp all 0", fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    fwd_addr_1 = 5'd0; fwd_addr_2 = 5'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);
    #1;
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %b exp 0", wb_enable); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    tests++; if (wb_enable !== 1'b1 || wb_addr !== 6'd3 || wb_data !== 32'hDEAD_BEEF || count !== 3'd1) begin
      fails++; $display("FAIL single_write got en=%b addr=%0d data=%h cnt=%0d exp 1/3/deadbeef/1", wb_enable, wb_addr, wb_data, count);
    end
    tick();
    tests++; if (count !== 3'd0 || wb_enable !== 1'b0) begin
      fails++; $display("FAIL single_after got cnt=%0d en=%b exp 0/0", count, wb_enable);
    end
  endtask

  task automatic test_fill_stall();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
      tick();
    end
    drive(1'b1, 5'd7, 32'h0000_0055, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (count !== 3'd4 || in_ready !== 1'b0 || wb_enable !== 1'b0) begin
        fails++; $display("FAIL full_hold got cnt=%0d rdy=%b en=%b exp 4/0/0", count, in_ready, wb_enable);
      end
      tick();
    end
    wb_stall = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_release_ready got %b exp 1", in_ready); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      #1; compute_exp();
      tests++; if (wb_enable !== 1'b1 || wb_addr !== e_addr || wb_data !== e_data) begin
        fails++; $display("FAIL drain_order[%0d] got en=%b addr=%0d data=%h exp 1/%0d/%h", k, wb_enable, wb_addr, wb_data, e_addr, e_data);
      end
      tick();
      in_valid = 1'b0;
    end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL drain_empty got %0d exp 0", count); end
  endtask

  task automatic test_full_stream();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
      #1; compute_exp();
      tests++; if (in_ready !== 1'b1 || wb_enable !== 1'b1 || count !== 3'd4) begin
        fails++; $display("FAIL stream_flow[%0d] got rdy=%b en=%b cnt=%0d exp 1/1/4", k, in_ready, wb_enable, count);
      end
      tests++; if (wb_addr !== e_addr || wb_data !== e_data) begin
        fails++; $display("FAIL stream_data[%0d] got %0d/%h exp %0d/%h", k, wb_addr, wb_data, e_addr, e_data);
      end
      tick();
    end
    drain();
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL stream_drain got %0d exp 0", count); end
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rd0_ready got %b exp 1", in_ready); end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    tests++; if (count !== 3'd0 || wb_enable !== 1'b0) begin
      fails++; $display("FAIL rd0_discard got cnt=%0d en=%b exp 0/0", count, wb_enable);
    end
  endtask

  task automatic test_forward();
    drive(1'b1, 5'd5, 32'h0000_000A, 1'b1); tick();
    drive(1'b1, 5'd5, 32'h0000_000B, 1'b1); tick();
    drive(1'b1, 5'd5, 32'h0000_000C, 1'b1);
    fwd_addr_1 = 5'd5; fwd_addr_2 = 5'd0;
    #1;
`ifdef WB_QUEUE_FORWARD_EN
    tests++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 32'h0000_000B) begin
      fails++; $display("FAIL fwd_newest got hit=%b data=%h exp 1/0000000b", fwd_hit_1, fwd_data_1);
    end
`else
    tests++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 32'd0) begin
      fails++; $display("FAIL fwd_disabled got hit=%b data=%h exp 0/0", fwd_hit_1, fwd_data_1);
    end
`endif
    tests++; if (fwd_hit_2 !== 1'b0 || fwd_data_2 !== 32'd0) begin
      fails++; $display("FAIL fwd_x0 got hit=%b data=%h exp 0/0", fwd_hit_2, fwd_data_2);
    end
    tick();
    fwd_addr_1 = 5'd0;
    drain();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    #2;
    wb_stall = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (count !== 3'd0 || wb_enable !== 1'b0) begin
      fails++; $display("FAIL async_rst got cnt=%0d en=%b exp 0/0", count, wb_enable);
    end
    q_rd.delete(); q_data.delete();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++; if (wb_enable !== 1'b0 || count !== 3'd0) begin
        fails++; $display("FAIL post_rst_write[%0d] got en=%b cnt=%0d exp 0/0", k, wb_enable, count);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 4);
      fwd_addr_1 = 5'($urandom_range(0, 7));
      fwd_addr_2 = 5'($urandom_range(0, 7));
      #1; compute_exp();
      tests++; if (count !== e_count || in_ready !== e_ready || wb_enable !== e_pop) begin
        fails++; $display("FAIL rand_ctrl[%0d] got cnt=%0d rdy=%b en=%b exp %0d/%b/%b", k, count, in_ready, wb_enable, e_count, e_ready, e_pop);
      end
      tests++; if (wb_addr !== e_addr || wb_data !== e_data) begin
        fails++; $display("FAIL rand_wb[%0d] got %0d/%h exp %0d/%h", k, wb_addr, wb_data, e_addr, e_data);
      end
      tests++; if (fwd_hit_1 !== e_hit1 || fwd_data_1 !== e_fd1 || fwd_hit_2 !== e_hit2 || fwd_data_2 !== e_fd2) begin
        fails++; $display("FAIL rand_fwd[%0d] got %b/%h %b/%h exp %b/%h %b/%h", k, fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, e_hit1, e_fd1, e_hit2, e_fd2);
      end
      tick();
    end
    fwd_addr_1 = 5'd0; fwd_addr_2 = 5'd0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_full_stream();
    test_rd_zero();
    test_forward();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queued write requests; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: execute stage presents a write request.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the queue accepts the request this cycle.
REQ-006 The block SHALL have port in_rd, input, 5 bits: destination register index.
REQ-007 The block SHALL have port in_data, input, bus_t (32 bits): result value.
REQ-008 The block SHALL have port wb_stall, input, 1 bit: the register-file write port is unavailable this cycle.
REQ-009 The block SHALL have port wb_enable, output, 1 bit: register-file write enable.
REQ-010 The block SHALL have port wb_addr, output, 6 bits: register-file write address; bit 5 is always 0.
REQ-011 The block SHALL have port wb_data, output, bus_t: register-file write data.
REQ-012 The block SHALL have ports fwd_addr_1 and fwd_addr_2, input, 5 bits each: operand lookup indices.
REQ-013 The block SHALL have ports fwd_hit_1 and fwd_hit_2, output, 1 bit each: a queued value exists for the index.
REQ-014 The block SHALL have ports fwd_data_1 and fwd_data_2, output, bus_t each: the forwarded value.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the number of queued entries.

Function
REQ-016 The queue SHALL be a FIFO of {rd, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-017 pop = (count != 0) && !wb_stall; wb_enable SHALL equal pop, combinationally.
REQ-018 wb_addr/wb_data SHALL be {1'b0, head.rd}/head.data when count != 0, and 0 otherwise.
REQ-019 in_ready = (count < DEPTH) || pop; this path is combinational from wb_stall.
REQ-020 Accept = in_valid && in_ready; an accepted request with in_rd != 0 SHALL be pushed at the tail.
REQ-021 An accepted request with in_rd == 0 SHALL be consumed and discarded, with count unchanged.
REQ-022 Latency: a request pushed at edge N SHALL appear on wb_* in cycle N+1 at the earliest (empty queue, no stall).
REQ-023 Simultaneous push and pop SHALL leave count unchanged; this holds when full (pop frees the slot) and when count is 1 (head advances, new entry becomes head).
REQ-024 With count == 0, pop SHALL be 0 regardless of wb_stall; the queue has no empty-bypass.
REQ-025 Order SHALL be strict FIFO; duplicate rd entries SHALL all be written, in order.
REQ-026 count SHALL never exceed DEPTH or underflow; in_valid while full and stalled SHALL leave state unchanged (in_ready = 0).
REQ-027 Forward lookup (combinational): fwd_hit_k = 1 if any queued entry has rd == fwd_addr_k != 0; fwd_data_k = data of the newest such entry; otherwise hit = 0 and data = 0.
REQ-028 Lookup SHALL include the head entry being popped this cycle and SHALL exclude the request being accepted this cycle.

Reset
REQ-029 While rst = 1 (asynchronous), head, tail and count SHALL be 0; wb_enable, wb_addr, wb_data, fwd_hit_* and fwd_data_* SHALL be 0; in_ready SHALL be 1.
REQ-030 Reset mid-operation SHALL discard all queued entries without any write; entry storage need not be reset.

Configuration
REQ-031 Macro WB_QUEUE_FORWARD_EN: when defined, REQ-027/028 are implemented; when undefined, no lookup logic is built, fwd_hit_* and fwd_data_* are tied to 0, and fwd_addr_* are ignored.

Verification
REQ-032 Scenario: push rd=3 data=0xDEADBEEF, no stall -> next cycle wb_enable=1, wb_addr=3, wb_data=0xDEADBEEF, count 1->0.
REQ-033 Scenario: wb_stall=1; push 4 entries (DEPTH=4) -> count=4, in_ready=0; a 5th in_valid is held; release stall -> 4 writes in push order, then the 5th.
REQ-034 Scenario: full, wb_stall=0, in_valid=1 -> in_ready=1, push and pop same cycle, count stays 4; head/tail wrap verified over 10 cycles.
REQ-035 Scenario: push rd=0 data=0x1234 -> accepted, count stays 0, no wb_enable.
REQ-036 Scenario (FORWARD_EN): stall; push rd=5 data=0xA then rd=5 data=0xB; fwd_addr_1=5 -> hit=1, data=0xB; fwd_addr_2=0 -> hit=0; without the macro both hits=0.
REQ-037 Scenario: 3 entries queued, assert rst asynchronously mid-cycle -> count=0 and wb_enable=0 immediately; no writes after release.
